matrix_keypad_scanner: RTL and testbench
========================================

Name: matrix_keypad_scanner

Overview:
- Parametrised ROWS x COLS matrix keypad scanner. It drives rows active-low in rotation and samples the columns.
- Each key gets a per-key frame-count debounce, so glitches are rejected at frame granularity.
- Outputs are debounced key state, press/release pulses, and a valid/ready key-event stream (key code plus press/release flag).
- Sits between the board keypad pins and the tone/control logic of the Electric_Piano design.

Parameters:
- ROWS, 4, number of driven rows (2..8).
- COLS, 4, number of sampled columns (2..8).
- CLK_FREQ, 12_000_000, clk frequency in Hz.
- SCAN_FREQ, 1000, full-frame scan rate in Hz.
- DEBOUNCE_SCANS, 4, consecutive identical frames required to change a key's state (1..15).
- ROW_CYC, CLK_FREQ/(SCAN_FREQ*ROWS), derived; clk cycles per row slot. Elaboration error if ROW_CYC < 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- col  in  COLS  column inputs, active-low, asynchronous to clk
- row  out  ROWS  row drive; exactly one bit low
- key_state  out  ROWS*COLS  debounced state, 1 = pressed; index = r*COLS+c
- key_press  out  ROWS*COLS  one-cycle pulse per debounced press
- key_release  out  ROWS*COLS  one-cycle pulse per debounced release
- evt_valid  out  1  key event available
- evt_ready  in  1  consumer accepts event
- evt_code  out  $clog2(ROWS*COLS)  key index of event
- evt_press  out  1  1 = press event, 0 = release event
- evt_ovf  out  1  sticky: an event was lost
- ovf_clr  in  1  clears evt_ovf

Behaviour:
- Reset values:
  - row = all ones except bit0 = 0.
  - key_state, key_press, key_release, evt_valid, evt_code, evt_press, evt_ovf = 0.
  - All counters = 0. Raw frame register = all ones (released).
- col passes through a 2-flop synchroniser.
- Row slot counter runs 0..ROW_CYC-1. The synchronised col is captured into raw bits [r*COLS +: COLS] on the last cycle of slot r, then row advances to r+1, wrapping ROWS-1 -> 0.
- A frame ends on the last cycle of slot ROWS-1. On that cycle the assembled raw frame (inverted, 1 = pressed) is presented to the debouncers.
- Per key, at frame end:
  - If raw != key_state, the counter increments.
  - When the counter reaches DEBOUNCE_SCANS, key_state toggles and the counter clears.
  - If raw == key_state, the counter clears. One bouncing frame restarts the count.
- key_press/key_release are registered together with the key_state update. They are high for exactly the one cycle after the updating edge.
- Event queue:
  - pending_press/pending_release masks are set by the pulses.
  - The selected event is the lowest index with any pending bit; press is chosen before release at the same index.
  - evt_valid is registered and asserts the cycle after a pulse.
  - evt_code/evt_press are held stable while evt_valid=1 and evt_ready=0.
  - On evt_valid and evt_ready, the reported pending bit clears. The next event is presented the following cycle (one-cycle bubble is allowed).
- Overflow: a pulse that arrives while the same pending bit is already set sets evt_ovf. The event is merged (not duplicated).
  - ovf_clr clears evt_ovf.
  - If ovf_clr and a new overflow occur in the same cycle, overflow wins (evt_ovf stays 1).
- A set pulse and a clear of the same bit in the same cycle: the bit stays set (the new event is kept).
- Multiple simultaneous key changes in one frame: all are pulsed in the same cycle and queued in index order.
- Reset asserted mid-frame: all state returns to reset values immediately. Partial frame and pending events are discarded.

Decomposition:
- Package kp_pkg holds:
  - function row_cycles(CLK_FREQ, SCAN_FREQ, ROWS);
  - localparam KEYS = ROWS*COLS;
  - CODE_W = $clog2(KEYS);
  - counter width $clog2(DEBOUNCE_SCANS+1).
- Sub-module kp_key_debounce (one key: counter, state, press/release pulse) is instantiated KEYS times via generate.
- The row scanner and event arbiter stay in the top.

Test Plan:
- All tests use CLK_FREQ=64000, SCAN_FREQ=1000, ROWS=COLS=4, DEBOUNCE_SCANS=3, so ROW_CYC=16 and a frame is 64 cycles.
- Reset, no keys -> row=1110, held 16 cycles, then 1101, 1011, 0111, 1110; key_state=0; evt_valid=0 throughout.
- Key 6 (row1, col2) held pressed -> key_state[6]=1 at the end of the 3rd full frame; key_press[6] pulses once; with evt_ready=1, one event evt_code=6, evt_press=1. Release -> key_release[6] and evt_code=6, evt_press=0.
- Key 6 asserted for 2 frames, then released (bounce) -> key_state unchanged, no pulses, no events.
- Keys 1 and 9 pressed in the same frame, evt_ready=0 for 10 cycles -> evt_valid=1, evt_code=1 stable all 10 cycles; after the handshake, evt_code=9; then evt_valid=0.
- evt_ready=0; key 5 press, release, press -> evt_ovf=1 after the second press. Queued events: press 5, release 5. ovf_clr pulse -> evt_ovf=0.
- Key 3 debouncing (counter=2), rst_n pulsed low mid-slot -> row=1110, key_state=0, counters restart; 3 more frames are needed before key_state[3]=1.

Source files
------------

// File: rtl/kp_pkg.sv
// Shared sizing helpers for the matrix keypad scanner and its per-key debouncers.
package kp_pkg;

  function automatic int unsigned row_cycles(int unsigned clk_freq, int unsigned scan_freq,
                                             int unsigned rows);
    return clk_freq / (scan_freq * rows);
  endfunction

  function automatic int unsigned cnt_width(int unsigned debounce_scans);
    return $clog2(debounce_scans + 1);
  endfunction

  function automatic int unsigned code_width(int unsigned keys);
    return (keys > 1) ? $clog2(keys) : 1;
  endfunction

endpackage

// File: rtl/kp_key_debounce.sv
// One key's frame-count debouncer: counts consecutive frames that disagree with the
// debounced state and toggles it, with a one-cycle press/release pulse, after enough.
module kp_key_debounce
  import kp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_frame_end,
  input  logic i_raw,
  output logic o_state,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_state;
  logic             r_press;
  logic             r_release;
  logic             w_differ;
  logic             w_flip;

  assign w_differ = i_raw ^ r_state;
  assign w_flip   = i_frame_end & w_differ & (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_state   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_flip & ~r_state;
      r_release <= w_flip & r_state;
      if (i_frame_end) begin
        // A single agreeing frame restarts the count.
        if (!w_differ || w_flip) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_flip) begin
          r_state <= ~r_state;
        end
      end
    end
  end

  assign o_state   = r_state;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/matrix_keypad_scanner.sv
// Row-rotating matrix keypad scanner with per-key debounce and a valid/ready event queue
// of press/release events, served lowest key index first.
module matrix_keypad_scanner
  import kp_pkg::*;
#(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned CLK_FREQ       = 12_000_000,
  parameter int unsigned SCAN_FREQ      = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  localparam int unsigned KEYS          = ROWS * COLS,
  localparam int unsigned CODE_W        = code_width(KEYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [COLS-1:0]   col,
  output logic [ROWS-1:0]   row,
  output logic [KEYS-1:0]   key_state,
  output logic [KEYS-1:0]   key_press,
  output logic [KEYS-1:0]   key_release,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_press,
  output logic              evt_ovf,
  input  logic              ovf_clr
);

  localparam int unsigned ROW_CYC = row_cycles(CLK_FREQ, SCAN_FREQ, ROWS);
  localparam int unsigned SLOT_W  = $clog2(ROW_CYC);
  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned RAW_W   = (ROWS - 1) * COLS;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(ROW_CYC - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ROWS-1:0]   ROW_INIT  = {{(ROWS - 1){1'b1}}, 1'b0};

  if (ROW_CYC < 4) begin : g_row_cyc_check
    $error("matrix_keypad_scanner: ROW_CYC must be at least 4");
  end

  // ---------------------------------------------------------------------------
  // Column synchroniser and row scan
  // ---------------------------------------------------------------------------
  logic [COLS-1:0]   r_col_meta;
  logic [COLS-1:0]   r_col_sync;
  logic [SLOT_W-1:0] r_slot_cnt;
  logic [ROW_W-1:0]  r_row_idx;
  logic [ROWS-1:0]   r_row;
  // Rows 0..ROWS-2 only; the last row is taken straight from the synchroniser.
  logic [RAW_W-1:0]  r_raw;
  logic              w_slot_last;
  logic              w_frame_end;
  logic [KEYS-1:0]   w_pressed;

  assign w_slot_last = (r_slot_cnt == SLOT_LAST);
  assign w_frame_end = w_slot_last & (r_row_idx == ROW_LAST);
  assign w_pressed   = ~{r_col_sync, r_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_meta <= '1;
      r_col_sync <= '1;
      r_slot_cnt <= '0;
      r_row_idx  <= '0;
      r_row      <= ROW_INIT;
      r_raw      <= '1;
    end else begin
      r_col_meta <= col;
      r_col_sync <= r_col_meta;
      if (w_slot_last) begin
        r_slot_cnt <= '0;
        for (int r = 0; r < int'(ROWS) - 1; r++) begin
          if (r_row_idx == ROW_W'(r)) begin
            r_raw[r*COLS +: COLS] <= r_col_sync;
          end
        end
        r_row     <= {r_row[ROWS-2:0], r_row[ROWS-1]};
        r_row_idx <= (r_row_idx == ROW_LAST) ? '0 : r_row_idx + 1'b1;
      end else begin
        r_slot_cnt <= r_slot_cnt + 1'b1;
      end
    end
  end

  assign row = r_row;

  // ---------------------------------------------------------------------------
  // Per-key debouncers
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < KEYS; k++) begin : g_key
    kp_key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_frame_end(w_frame_end),
      .i_raw      (w_pressed[k]),
      .o_state    (key_state[k]),
      .o_press    (key_press[k]),
      .o_release  (key_release[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Event queue and arbiter
  // ---------------------------------------------------------------------------
  logic [KEYS-1:0]   r_pend_press;
  logic [KEYS-1:0]   r_pend_rel;
  logic              r_evt_valid;
  logic [CODE_W-1:0] r_evt_code;
  logic              r_evt_press;
  logic              r_evt_ovf;
  logic              w_ack;
  logic [KEYS-1:0]   w_clr_press;
  logic [KEYS-1:0]   w_clr_rel;
  logic [KEYS-1:0]   w_pend_press_d;
  logic [KEYS-1:0]   w_pend_rel_d;
  logic              w_ovf_hit;
  logic              w_sel_any;
  logic [CODE_W-1:0] w_sel_code;
  logic              w_sel_press;

  assign w_ack = r_evt_valid & evt_ready;

  always_comb begin
    w_clr_press = '0;
    w_clr_rel   = '0;
    if (w_ack) begin
      if (r_evt_press) begin
        w_clr_press[r_evt_code] = 1'b1;
      end else begin
        w_clr_rel[r_evt_code] = 1'b1;
      end
    end
  end

  // A new pulse wins over the clear of the same bit, so the fresh event is kept.
  assign w_pend_press_d = (r_pend_press & ~w_clr_press) | key_press;
  assign w_pend_rel_d   = (r_pend_rel & ~w_clr_rel) | key_release;
  assign w_ovf_hit      = |((key_press & r_pend_press & ~w_clr_press) |
                            (key_release & r_pend_rel & ~w_clr_rel));
  assign w_sel_any      = |(w_pend_press_d | w_pend_rel_d);

  always_comb begin
    w_sel_code  = '0;
    w_sel_press = 1'b0;
    for (int i = int'(KEYS) - 1; i >= 0; i--) begin
      if (w_pend_press_d[i] || w_pend_rel_d[i]) begin
        w_sel_code  = CODE_W'(i);
        w_sel_press = w_pend_press_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_press <= '0;
      r_pend_rel   <= '0;
      r_evt_valid  <= 1'b0;
      r_evt_code   <= '0;
      r_evt_press  <= 1'b0;
      r_evt_ovf    <= 1'b0;
    end else begin
      r_pend_press <= w_pend_press_d;
      r_pend_rel   <= w_pend_rel_d;
      // Presented event is frozen until it is accepted.
      if (!r_evt_valid || w_ack) begin
        r_evt_valid <= w_sel_any;
        r_evt_code  <= w_sel_code;
        r_evt_press <= w_sel_press;
      end
      if (w_ovf_hit) begin
        r_evt_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_evt_ovf <= 1'b0;
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_code  = r_evt_code;
  assign evt_press = r_evt_press;
  assign evt_ovf   = r_evt_ovf;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner: a keypad model drives col from row, a vector
// table covers scan timing and a full press/release, hand sequences cover the rest.
module tb_matrix_keypad_scanner;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned KEYS = ROWS * COLS;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] key_state;
  logic [15:0] key_press;
  logic [15:0] key_release;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_code;
  logic        evt_press;
  logic        evt_ovf;
  logic        ovf_clr;
  logic [15:0] keys_down;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned mon_press;
  int unsigned mon_rel;
  int unsigned mon_valid;
  logic [15:0] mon_last_press;

  matrix_keypad_scanner #(
    .ROWS          (ROWS),
    .COLS          (COLS),
    .CLK_FREQ      (64000),
    .SCAN_FREQ     (1000),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .col        (col),
    .row        (row),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_press  (evt_press),
    .evt_ovf    (evt_ovf),
    .ovf_clr    (ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Passive keypad: a held key pulls its column low while its row is driven low.
  always_comb begin
    col = '1;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (!row[r]) begin
        for (int c = 0; c < int'(COLS); c++) begin
          if (keys_down[r*COLS+c]) col[c] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (key_press != 16'h0) begin
      mon_press      <= mon_press + 1;
      mon_last_press <= key_press;
    end
    if (key_release != 16'h0) mon_rel <= mon_rel + 1;
    if (evt_valid) mon_valid <= mon_valid + 1;
  end

  initial begin
    mon_press      = 0;
    mon_rel        = 0;
    mon_valid      = 0;
    mon_last_press = '0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // From a negedge, move exactly n active edges forward and stop on the next negedge.
  task automatic adv(input int unsigned n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input int unsigned budget, input string name);
    int unsigned i;
    i = 0;
    while (!evt_valid && i < budget) begin
      adv(1);
      i++;
    end
    chk({name, "_valid_in_time"}, {31'h0, evt_valid}, 32'h1);
  endtask

  typedef struct {
    int unsigned adv;
    logic [15:0] keys;
    logic        ready;
    logic [3:0]  e_row;
    logic [15:0] e_state;
    logic [15:0] e_press;
    logic [15:0] e_rel;
    logic        e_valid;
    logic        chk_evt;
    logic [3:0]  e_code;
    logic        e_epress;
  } vec_t;

  vec_t tbl[14];

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    keys_down = '0;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;

    // Edges counted from reset release; a frame is 64 edges, a row slot 16.
    tbl[0]  = '{1,   16'h0000, 1'b1, 4'b1110, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{14,  16'h0000, 1'b1, 4'b1110, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{1,   16'h0000, 1'b1, 4'b1101, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{16,  16'h0000, 1'b1, 4'b1011, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[4]  = '{16,  16'h0000, 1'b1, 4'b0111, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[5]  = '{16,  16'h0000, 1'b1, 4'b1110, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[6]  = '{128, 16'h0040, 1'b1, 4'b1110, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[7]  = '{63,  16'h0040, 1'b1, 4'b0111, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[8]  = '{1,   16'h0040, 1'b1, 4'b1110, 16'h0040, 16'h0040, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[9]  = '{1,   16'h0040, 1'b1, 4'b1110, 16'h0040, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'd6, 1'b1};
    tbl[10] = '{1,   16'h0040, 1'b1, 4'b1110, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[11] = '{190, 16'h0000, 1'b1, 4'b1110, 16'h0000, 16'h0000, 16'h0040, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[12] = '{1,   16'h0000, 1'b1, 4'b1110, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'd6, 1'b0};
    tbl[13] = '{1,   16'h0000, 1'b1, 4'b1110, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0};

    adv(3);
    chk("inreset_row", {28'h0, row}, 32'hE);
    rst_n = 1'b1;
    chk("reset_row", {28'h0, row}, 32'hE);
    chk("reset_state", {16'h0, key_state}, 32'h0);
    chk("reset_pulses", {key_press, key_release}, 32'h0);
    chk("reset_evt", {28'h0, evt_valid, evt_press, evt_ovf, 1'b0}, 32'h0);
    chk("reset_code", {28'h0, evt_code}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      keys_down = tbl[i].keys;
      evt_ready = tbl[i].ready;
      adv(tbl[i].adv);
      chk($sformatf("v%0d_row", i), {28'h0, row}, {28'h0, tbl[i].e_row});
      chk($sformatf("v%0d_state", i), {16'h0, key_state}, {16'h0, tbl[i].e_state});
      chk($sformatf("v%0d_press", i), {16'h0, key_press}, {16'h0, tbl[i].e_press});
      chk($sformatf("v%0d_release", i), {16'h0, key_release}, {16'h0, tbl[i].e_rel});
      chk($sformatf("v%0d_valid", i), {31'h0, evt_valid}, {31'h0, tbl[i].e_valid});
      if (tbl[i].chk_evt) begin
        chk($sformatf("v%0d_code", i), {28'h0, evt_code}, {28'h0, tbl[i].e_code});
        chk($sformatf("v%0d_epress", i), {31'h0, evt_press}, {31'h0, tbl[i].e_epress});
      end
    end

    // Bounce: key 6 seen in exactly two frames, then released.
    begin
      int unsigned p0, r0, v0;
      p0 = mon_press;
      r0 = mon_rel;
      v0 = mon_valid;
      keys_down = 16'h0040;
      adv(126);
      keys_down = 16'h0000;
      adv(128);
      chk("bounce_state", {16'h0, key_state}, 32'h0);
      chk("bounce_press", mon_press - p0, 32'h0);
      chk("bounce_release", mon_rel - r0, 32'h0);
      chk("bounce_events", mon_valid - v0, 32'h0);
    end

    // Keys 1 and 9 in the same frame with the consumer stalled.
    keys_down = 16'h0202;
    evt_ready = 1'b0;
    wait_valid(300, "dual");
    chk("dual_pulse_vec", {16'h0, mon_last_press}, 32'h0202);
    chk("dual_state", {16'h0, key_state}, 32'h0202);
    chk("dual_first", {27'h0, evt_valid, evt_code, evt_press}, {27'h0, 1'b1, 4'd1, 1'b1});
    for (int i = 0; i < 10; i++) begin
      adv(1);
      chk($sformatf("dual_hold%0d", i), {27'h0, evt_valid, evt_code, evt_press},
          {27'h0, 1'b1, 4'd1, 1'b1});
    end
    evt_ready = 1'b1;
    adv(1);
    chk("dual_second", {27'h0, evt_valid, evt_code, evt_press}, {27'h0, 1'b1, 4'd9, 1'b1});
    adv(1);
    chk("dual_empty", {31'h0, evt_valid}, 32'h0);
    keys_down = 16'h0000;
    adv(300);
    chk("dual_released", {16'h0, key_state}, 32'h0);
    chk("dual_drained", {31'h0, evt_valid}, 32'h0);

    // Overflow: press, release, press of key 5 with nothing consumed.
    evt_ready = 1'b0;
    keys_down = 16'h0020;
    adv(260);
    chk("ovf_p1_state", {16'h0, key_state}, 32'h0020);
    chk("ovf_p1_evt", {27'h0, evt_valid, evt_code, evt_press}, {27'h0, 1'b1, 4'd5, 1'b1});
    chk("ovf_p1_flag", {31'h0, evt_ovf}, 32'h0);
    keys_down = 16'h0000;
    adv(260);
    chk("ovf_r1_state", {16'h0, key_state}, 32'h0);
    chk("ovf_r1_flag", {31'h0, evt_ovf}, 32'h0);
    chk("ovf_r1_hold", {27'h0, evt_valid, evt_code, evt_press}, {27'h0, 1'b1, 4'd5, 1'b1});
    keys_down = 16'h0020;
    adv(260);
    chk("ovf_p2_flag", {31'h0, evt_ovf}, 32'h1);
    evt_ready = 1'b1;
    adv(1);
    chk("ovf_q_release", {27'h0, evt_valid, evt_code, evt_press}, {27'h0, 1'b1, 4'd5, 1'b0});
    adv(1);
    chk("ovf_q_empty", {31'h0, evt_valid}, 32'h0);
    evt_ready = 1'b0;
    adv(2);
    chk("ovf_sticky", {31'h0, evt_ovf}, 32'h1);
    ovf_clr = 1'b1;
    adv(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'h0, evt_ovf}, 32'h0);

    // Key 3 mid-debounce, then an asynchronous reset in the middle of row slot 1.
    rst_n     = 1'b0;
    keys_down = 16'h0008;
    adv(2);
    rst_n = 1'b1;
    adv(64);
    chk("rst3_f1_state", {16'h0, key_state}, 32'h0);
    adv(86);
    chk("rst3_preset_row", {28'h0, row}, 32'hD);
    rst_n = 1'b0;
    #2;
    chk("rst3_async_row", {28'h0, row}, 32'hE);
    chk("rst3_async_state", {16'h0, key_state}, 32'h0);
    chk("rst3_async_evt", {30'h0, evt_valid, evt_ovf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    adv(64);
    chk("rst3_after_f1", {16'h0, key_state}, 32'h0);
    adv(127);
    chk("rst3_after_f3m1", {16'h0, key_state}, 32'h0);
    adv(1);
    chk("rst3_after_f3", {16'h0, key_state}, 32'h0008);
    chk("rst3_press", {16'h0, key_press}, 32'h0008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
